gf_arith_unit: RTL
==================

# gf_arith_unit

Sequential, parametrised GF(2^SYMB_WIDTH) arithmetic engine with valid/ready handshakes. It provides multiply, inverse, divide and Horner polynomial evaluation over a streamed coefficient sequence. It is the synthesizable, runtime-operand successor to the package's elaboration-time table functions, and is intended for Reed-Solomon decoder blocks (BM, Forney) that need division and evaluation without per-use full-field LUTs. Width and field polynomial are parameters; multiplication uses shift-and-xor logic, not tables.

## Interface
- SYMB_WIDTH, 8, symbol width m; legal range 3..16
- POLY, 285, primitive field polynomial, SYMB_WIDTH+1 bits; reduction uses POLY[SYMB_WIDTH-1:0]
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts a beat this cycle
- in_op  in  2  0 MULT, 1 INV, 2 DIV, 3 EVAL; sampled on first beat only
- in_a  in  SYMB_WIDTH  operand A / EVAL coefficient (highest degree first)
- in_b  in  SYMB_WIDTH  operand B / EVAL point x (latched on first beat)
- in_last  in  1  EVAL: final coefficient beat; ignored for other ops
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- out_data  out  SYMB_WIDTH  result symbol
- out_err  out  1  divide/invert by zero; qualified by out_valid

## Operation
- States: IDLE, INV_ITER, DIV_MUL, EVAL, DONE.
- in_ready = 1 in IDLE and EVAL only. A beat is accepted when in_valid & in_ready.
- IDLE, accept:
  - MULT: result = a·b -> DONE.
  - INV: sq = a², res = 1, cnt = 0 -> INV_ITER.
  - DIV: same as INV, with operand b; a is latched -> INV_ITER.
  - EVAL: acc = a, x = b. If in_last, go to DONE with acc. Otherwise go to EVAL.
- INV_ITER, each cycle: res = res·sq, sq = sq², cnt++. After SYMB_WIDTH-1 iterations res = operand^(2^m−2) = operand⁻¹.
  - INV -> DONE.
  - DIV -> DIV_MUL.
- DIV_MUL: result = a_latched·res -> DONE.
- EVAL, accept: acc = acc·x ⊕ a. If in_last -> DONE. in_op and in_b are ignored on continuation beats.
- DONE: out_valid = 1. out_data and out_err are stable until out_valid & out_ready, then IDLE.
- Zero operands:
  - INV of 0 or DIV with b = 0: out_data = 0, out_err = 1. Iterations still run; latency is unchanged.
  - DIV with a = 0, b ≠ 0: out_data = 0, out_err = 0.
  - MULT with either operand 0: 0.
- out_err = 0 for MULT and EVAL.
- GF multiply: m-step shift-and-xor. On each step, if the MSB of the partial result is set, shift left and xor POLY[SYMB_WIDTH-1:0]. All values are SYMB_WIDTH bits; no carries.
- rst asserted in any state, mid-operation included: immediately go to IDLE.
  - Outputs: out_valid = 0, out_data = 0, out_err = 0, in_ready = 0 while rst is high; in_ready = 1 in the first cycle after release.
  - Internal acc, x, sq, res and cnt clear to 0.
  - A partial EVAL is discarded.

## Timing
- Latency is measured from the accept edge to the first cycle with out_valid = 1.
  - MULT: 1.
  - INV: SYMB_WIDTH (1 setup plus SYMB_WIDTH−1 iterations). For m = 8 this is 8.
  - DIV: SYMB_WIDTH+1.
  - EVAL: 1 after the last-beat accept.
- EVAL accepts one coefficient per cycle with no bubbles. An n-coefficient polynomial completes n cycles after the first accept.
- Back-to-back MULT throughput is 1 result per 2 cycles, because DONE blocks input.
- out_ready held low keeps DONE indefinitely with outputs stable. in_valid during DONE is ignored and the beat is not consumed.

## Test plan
- MULT a=0x80, b=0x02 (m=8, POLY=285) -> out_data=0x1D, out_err=0, out_valid 1 cycle after accept.
- INV a=0x02 -> out_data=0x8E after exactly 8 cycles; INV a=0x01 -> 0x01.
- DIV a=0x1D, b=0x02 -> 0x80 after 9 cycles; DIV a=0x05, b=0x00 -> out_data=0x00, out_err=1.
- EVAL beats a=1,0,1 (last on third), b=2 on first beat -> out_data=0x05. Single beat a=0x37 with last -> 0x37.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no beat consumed. Then the result is taken and the next beat is accepted from IDLE.
- Assert rst during INV_ITER cycle 3 and during an EVAL after 2 beats -> out_valid=0 immediately. After release a fresh MULT 0x80·0x02 returns 0x1D with no stale state.

Source files
------------

// File: rtl/gf_arith_unit.sv
// Sequential GF(2^SYMB_WIDTH) engine: multiply, inverse, divide and Horner evaluation
// over a streamed coefficient sequence. Handshakes are valid/ready on both sides.
module gf_arith_unit #(
    parameter int          SYMB_WIDTH = 8,
    parameter int unsigned POLY       = 285
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [SYMB_WIDTH-1:0] in_a,
    input  logic [SYMB_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SYMB_WIDTH-1:0] out_data,
    output logic                  out_err
);

    localparam int CNT_W = $clog2(SYMB_WIDTH);
    localparam logic [SYMB_WIDTH-1:0] RED_POLY  = POLY[SYMB_WIDTH-1:0];
    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(SYMB_WIDTH - 2);
    localparam logic [SYMB_WIDTH-1:0] GF_ONE    = SYMB_WIDTH'(1);

    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_INV  = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_EVAL = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INV_ITER = 3'd1;
    localparam logic [2:0] S_DIV_MUL  = 3'd2;
    localparam logic [2:0] S_EVAL     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    // MSB-first shift-and-xor: reduce the partial product, then fold in a if b[i] is set.
    function automatic logic [SYMB_WIDTH-1:0] gf_mul(input logic [SYMB_WIDTH-1:0] a,
                                                     input logic [SYMB_WIDTH-1:0] b);
        logic [SYMB_WIDTH-1:0] p;
        p = '0;
        for (int i = SYMB_WIDTH - 1; i >= 0; i--) begin
            if (p[SYMB_WIDTH-1]) begin
                p = (p << 1) ^ RED_POLY;
            end else begin
                p = p << 1;
            end
            if (b[i]) begin
                p = p ^ a;
            end
        end
        return p;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [SYMB_WIDTH-1:0] a_q, a_d;
    logic [SYMB_WIDTH-1:0] x_q, x_d;
    logic [SYMB_WIDTH-1:0] acc_q, acc_d;
    logic [SYMB_WIDTH-1:0] sq_q, sq_d;
    logic [SYMB_WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  zero_q, zero_d;
    logic [SYMB_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  accept;

    assign in_ready  = ~rst & ((state_q == S_IDLE) | (state_q == S_EVAL));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = data_q;
    assign out_err   = err_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        x_d     = x_q;
        acc_d   = acc_q;
        sq_d    = sq_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = in_op;
                    case (in_op)
                        OP_MULT: begin
                            data_d  = gf_mul(in_a, in_b);
                            err_d   = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_INV: begin
                            sq_d    = gf_mul(in_a, in_a);
                            res_d   = GF_ONE;
                            cnt_d   = '0;
                            zero_d  = (in_a == '0);
                            state_d = S_INV_ITER;
                        end
                        OP_DIV: begin
                            a_d     = in_a;
                            sq_d    = gf_mul(in_b, in_b);
                            res_d   = GF_ONE;
                            cnt_d   = '0;
                            zero_d  = (in_b == '0);
                            state_d = S_INV_ITER;
                        end
                        default: begin
                            acc_d = in_a;
                            x_d   = in_b;
                            if (in_last) begin
                                data_d  = in_a;
                                err_d   = 1'b0;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_EVAL;
                            end
                        end
                    endcase
                end
            end

            // res accumulates operand^(2+4+...+2^k); after m-1 steps it is the inverse.
            // A zero operand collapses res to 0, so only the error flag needs special care.
            S_INV_ITER: begin
                res_d = gf_mul(res_q, sq_q);
                sq_d  = gf_mul(sq_q, sq_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    if (op_q == OP_DIV) begin
                        state_d = S_DIV_MUL;
                    end else begin
                        data_d  = res_d;
                        err_d   = zero_q;
                        state_d = S_DONE;
                    end
                end
            end

            S_DIV_MUL: begin
                data_d  = gf_mul(a_q, res_q);
                err_d   = zero_q;
                state_d = S_DONE;
            end

            S_EVAL: begin
                if (accept) begin
                    acc_d = gf_mul(acc_q, x_q) ^ in_a;
                    if (in_last) begin
                        data_d  = acc_d;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            sq_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            sq_q    <= sq_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule
